// File: rtl/ab_v2.sv
// rtl/ab_v2.sv - auto-gain pixel path: 4-stage gain multiply with per-frame luminance feedback
// Gain is swapped only on fv_in rise; statistics are gathered post-gain and evaluated in vblank.
module ab_v2 #(
  parameter int             DW          = 12,
  parameter int             GW          = 13,
  parameter int             FRAC        = 9,
  parameter logic [GW-1:0]  INIT_GAIN   = 13'h200,
  parameter logic [GW-1:0]  MIN_GAIN    = 13'h040,
  parameter logic [GW-1:0]  MAX_GAIN    = 13'h500,
  parameter int             STEP_FINE   = 4,
  parameter int             STEP_COARSE = 32,
  parameter int             MARGIN      = 64,
  parameter int             ACC_W       = 48,
  parameter int             CNT_W       = 24,
  parameter int             SKIP        = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data_in,
  input  logic          fv_in,
  input  logic          lv_in,
  input  logic          auto_en,
  input  logic [GW-1:0] man_gain,
  input  logic [DW-1:0] thr_upper,
  input  logic [DW-1:0] thr_lower,
  output logic [DW-1:0] data_out,
  output logic          fv_out,
  output logic          lv_out,
  output logic [GW-1:0] gain_out,
  output logic          eval_done
);

  localparam int PW = DW + GW;
  localparam int TW = DW + 1;
  localparam int MW = CNT_W + TW;
  localparam int CW = (ACC_W > MW) ? ACC_W : MW;
  localparam int SW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam logic [PW-1:0] PMAX = PW'({DW{1'b1}}) << FRAC;

  typedef enum logic [1:0] {ACCUM, EVAL, UPDATE} state_t;
  state_t state_q, state_d;

  logic [DW-1:0]    pix_q, clip_q, data_q;
  logic [PW-1:0]    prod_q;
  logic [3:0]       fv_sr_q, lv_sr_q;
  logic             fv_in_prev_q, auto_prev_q, fv_out_prev_q;
  logic [GW-1:0]    gain_act_q, gain_next_q;
  logic [ACC_W-1:0] sum_q, sum_lat_q;
  logic [CNT_W-1:0] cnt_q, cnt_lat_q;
  logic             hi_q, lo_q, coarse_q, upd_ok_q, eval_done_q;
  logic [SW-1:0]    skip_q;

  logic             fv_rise, auto_rise, frame_end, upd_en;
  logic [ACC_W:0]   sum_add;
  logic [TW-1:0]    thr_hi_m, thr_lo_m;
  logic [CW-1:0]    sum_x, up_x, low_x, upm_x, lowm_x;
  logic             hi, lo, coarse;
  logic [GW:0]      step, gn_x, dec_floor, inc_sum;
  logic [GW-1:0]    gn_dec, gn_inc, gn_clamp;

  assign fv_rise   = fv_in & ~fv_in_prev_q;
  assign auto_rise = auto_en & ~auto_prev_q;
  assign frame_end = ~fv_sr_q[3] & fv_out_prev_q;
  assign sum_add   = {1'b0, sum_q} + (ACC_W + 1)'(data_q);

  assign data_out  = data_q;
  assign fv_out    = fv_sr_q[3];
  assign lv_out    = lv_sr_q[3];
  assign gain_out  = gain_act_q;
  assign eval_done = eval_done_q;

  // Edge detectors follow the inputs through reset so a held fv_in/auto_en is not seen as a new edge.
  always_ff @(posedge clk) begin
    fv_in_prev_q <= fv_in;
    auto_prev_q  <= auto_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q   <= '0;
      prod_q  <= '0;
      clip_q  <= '0;
      data_q  <= '0;
      fv_sr_q <= '0;
      lv_sr_q <= '0;
    end else begin
      pix_q   <= data_in;
      prod_q  <= PW'(pix_q) * PW'(gain_act_q);
      clip_q  <= (prod_q > PMAX) ? {DW{1'b1}} : prod_q[FRAC +: DW];
      data_q  <= clip_q;
      fv_sr_q <= {fv_sr_q[2:0], fv_in};
      lv_sr_q <= {lv_sr_q[2:0], lv_in};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (frame_end) state_d = EVAL;
      EVAL:    state_d = UPDATE;
      UPDATE:  state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    thr_hi_m = {1'b0, thr_upper} + TW'(MARGIN);
    thr_lo_m = ({1'b0, thr_lower} > TW'(MARGIN)) ? ({1'b0, thr_lower} - TW'(MARGIN)) : '0;
    sum_x    = CW'(sum_lat_q);
    up_x     = CW'(cnt_lat_q) * CW'(thr_upper);
    low_x    = CW'(cnt_lat_q) * CW'(thr_lower);
    upm_x    = CW'(cnt_lat_q) * CW'(thr_hi_m);
    lowm_x   = CW'(cnt_lat_q) * CW'(thr_lo_m);
    hi       = sum_x > up_x;
    lo       = sum_x < low_x;
    coarse   = (sum_x > upm_x) || (sum_x < lowm_x);
  end

  always_comb begin
    step      = coarse_q ? (GW + 1)'(STEP_COARSE) : (GW + 1)'(STEP_FINE);
    gn_x      = {1'b0, gain_next_q};
    dec_floor = {1'b0, MIN_GAIN} + step;
    gn_dec    = (gn_x < dec_floor) ? MIN_GAIN : (gain_next_q - step[GW-1:0]);
    inc_sum   = gn_x + step;
    gn_inc    = (inc_sum > {1'b0, MAX_GAIN}) ? MAX_GAIN : inc_sum[GW-1:0];
    gn_clamp  = (gain_act_q < MIN_GAIN) ? MIN_GAIN :
                (gain_act_q > MAX_GAIN) ? MAX_GAIN : gain_act_q;
    upd_en    = (state_q == UPDATE) && upd_ok_q && auto_en && (cnt_lat_q != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ACCUM;
      fv_out_prev_q <= 1'b0;
      sum_q         <= '0;
      cnt_q         <= '0;
      sum_lat_q     <= '0;
      cnt_lat_q     <= '0;
      hi_q          <= 1'b0;
      lo_q          <= 1'b0;
      coarse_q      <= 1'b0;
      upd_ok_q      <= 1'b0;
      skip_q        <= '0;
      eval_done_q   <= 1'b0;
      gain_act_q    <= INIT_GAIN;
      gain_next_q   <= INIT_GAIN;
    end else begin
      state_q       <= state_d;
      fv_out_prev_q <= fv_sr_q[3];
      eval_done_q   <= (state_q == UPDATE);

      if ((state_q == ACCUM) && frame_end) begin
        sum_lat_q <= sum_q;
        cnt_lat_q <= cnt_q;
        sum_q     <= '0;
        cnt_q     <= '0;
      end else if (lv_sr_q[3]) begin
        sum_q <= sum_add[ACC_W] ? {ACC_W{1'b1}} : sum_add[ACC_W-1:0];
        cnt_q <= (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      end

      // hi has priority so an inverted band still resolves to a single direction.
      if (state_q == EVAL) begin
        hi_q     <= hi;
        lo_q     <= lo & ~hi;
        coarse_q <= coarse;
        upd_ok_q <= (skip_q == '0);
        skip_q   <= (skip_q == SW'(SKIP)) ? '0 : skip_q + 1'b1;
      end

      if (fv_rise) gain_act_q <= auto_en ? gain_next_q : man_gain;

      if (auto_rise) gain_next_q <= gn_clamp;
      else if (upd_en && hi_q) gain_next_q <= gn_dec;
      else if (upd_en && lo_q) gain_next_q <= gn_inc;
    end
  end

endmodule

// File: tb/tb_ab_v2.sv
// tb/tb_ab_v2.sv - directed bench for ab_v2 (default instance plus a SKIP=2 instance)
module tb_ab_v2;
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] data_in;
  logic        fv_in, lv_in, auto_en;
  logic [12:0] man_gain;
  logic [11:0] thr_upper, thr_lower;
  logic [11:0] data_out, data_out2;
  logic        fv_out, lv_out, eval_done, fv_out2, lv_out2, eval_done2;
  logic [12:0] gain_out, gain_out2;
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  ab_v2 dut (
    .clk(clk), .rst(rst), .data_in(data_in), .fv_in(fv_in), .lv_in(lv_in),
    .auto_en(auto_en), .man_gain(man_gain), .thr_upper(thr_upper), .thr_lower(thr_lower),
    .data_out(data_out), .fv_out(fv_out), .lv_out(lv_out), .gain_out(gain_out),
    .eval_done(eval_done)
  );

  ab_v2 #(.SKIP(2)) dut2 (
    .clk(clk), .rst(rst), .data_in(data_in), .fv_in(fv_in), .lv_in(lv_in),
    .auto_en(auto_en), .man_gain(man_gain), .thr_upper(thr_upper), .thr_lower(thr_lower),
    .data_out(data_out2), .fv_out(fv_out2), .lv_out(lv_out2), .gain_out(gain_out2),
    .eval_done(eval_done2)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic vblank(output int pulses, output int pulses2);
    pulses = 0;
    pulses2 = 0;
    fv_in = 1'b0;
    lv_in = 1'b0;
    data_in = 12'd0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (eval_done) pulses++;
      if (eval_done2) pulses2++;
    end
  endtask

  // 8x4 active frame of constant pixels followed by vblank long enough for EVAL/UPDATE.
  task automatic run_frame(input logic [11:0] pix, output logic [12:0] g1, output logic [12:0] g2,
                           output logic [11:0] first, output int pulses);
    bit got = 1'b0;
    int p2;
    first = 12'd0;
    fv_in = 1'b1;
    lv_in = 1'b0;
    data_in = 12'd0;
    tick();
    g1 = gain_out;
    g2 = gain_out2;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 10; x++) begin
        lv_in = (x < 8);
        data_in = (x < 8) ? pix : 12'd0;
        tick();
        if (lv_out && !got) begin
          first = data_out;
          got = 1'b1;
        end
      end
    end
    vblank(pulses, p2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    data_in = 12'hABC;
    fv_in = 1'b0;
    lv_in = 1'b0;
    auto_en = 1'b0;
    man_gain = 13'h200;
    thr_upper = 12'd1200;
    thr_lower = 12'd1100;
    repeat (3) tick();
    vecs++; if (data_out !== 12'd0) begin errs++; $display("FAIL rst_data got=%h exp=0", data_out); end
    vecs++; if (fv_out !== 1'b0) begin errs++; $display("FAIL rst_fv got=%b exp=0", fv_out); end
    vecs++; if (lv_out !== 1'b0) begin errs++; $display("FAIL rst_lv got=%b exp=0", lv_out); end
    vecs++; if (eval_done !== 1'b0) begin errs++; $display("FAIL rst_eval got=%b exp=0", eval_done); end
    vecs++; if (gain_out !== 13'h200) begin errs++; $display("FAIL rst_gain got=%h exp=200", gain_out); end
    vecs++; if (data_out2 !== 12'd0) begin errs++; $display("FAIL rst_data2 got=%h exp=0", data_out2); end
    vecs++; if (fv_out2 !== 1'b0) begin errs++; $display("FAIL rst_fv2 got=%b exp=0", fv_out2); end
    vecs++; if (lv_out2 !== 1'b0) begin errs++; $display("FAIL rst_lv2 got=%b exp=0", lv_out2); end
    vecs++; if (eval_done2 !== 1'b0) begin errs++; $display("FAIL rst_eval2 got=%b exp=0", eval_done2); end
    vecs++; if (gain_out2 !== 13'h200) begin errs++; $display("FAIL rst_gain2 got=%h exp=200", gain_out2); end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    int p, p2;
    data_in = 12'd0;
    tick();
    tick();
    fv_in = 1'b1;
    lv_in = 1'b1;
    data_in = 12'd100;
    repeat (3) tick();
    vecs++; if (fv_out !== 1'b0 || lv_out !== 1'b0) begin errs++; $display("FAIL lat_early got fv=%b lv=%b exp 0 0", fv_out, lv_out); end
    tick();
    vecs++; if (data_out !== 12'd100) begin errs++; $display("FAIL lat_data got=%0d exp=100", data_out); end
    vecs++; if (fv_out !== 1'b1 || lv_out !== 1'b1) begin errs++; $display("FAIL lat_fvlv got fv=%b lv=%b exp 1 1", fv_out, lv_out); end
    vblank(p, p2);
    vecs++; if (p !== 1) begin errs++; $display("FAIL lat_evalpulse got=%0d exp=1", p); end
  endtask

  task automatic test_saturation();
    int p, p2;
    man_gain = 13'h400;
    fv_in = 1'b1;
    lv_in = 1'b1;
    data_in = 12'hC00;
    tick();
    vecs++; if (gain_out !== 13'h400) begin errs++; $display("FAIL sat_gain got=%h exp=400", gain_out); end
    data_in = 12'h400;
    tick();
    lv_in = 1'b0;
    data_in = 12'd0;
    tick();
    tick();
    vecs++; if (data_out !== 12'hFFF) begin errs++; $display("FAIL sat_clip got=%h exp=fff", data_out); end
    tick();
    vecs++; if (data_out !== 12'h800) begin errs++; $display("FAIL sat_pass got=%h exp=800", data_out); end
    vblank(p, p2);
  endtask

  task automatic test_fine_step();
    logic [12:0] g1, g2;
    logic [11:0] first;
    int p;
    auto_en = 1'b1;
    thr_upper = 12'd1200;
    thr_lower = 12'd1100;
    do_reset();
    run_frame(12'd1180, g1, g2, first, p);
    vecs++; if (first !== 12'd1180) begin errs++; $display("FAIL fine_data1 got=%0d exp=1180", first); end
    vecs++; if (p !== 1) begin errs++; $display("FAIL fine_pulse got=%0d exp=1", p); end
    run_frame(12'd1210, g1, g2, first, p);
    vecs++; if (g1 !== 13'h200) begin errs++; $display("FAIL fine_hold got=%h exp=200", g1); end
    run_frame(12'd1180, g1, g2, first, p);
    vecs++; if (g1 !== 13'h1FC) begin errs++; $display("FAIL fine_down got=%h exp=1fc", g1); end
    vecs++; if (first !== 12'd1170) begin errs++; $display("FAIL fine_data3 got=%0d exp=1170", first); end
  endtask

  task automatic test_priority();
    logic [12:0] g1, g2;
    logic [11:0] first;
    int p;
    thr_upper = 12'd1100;
    thr_lower = 12'd1200;
    do_reset();
    run_frame(12'd1150, g1, g2, first, p);
    vecs++; if (g1 !== 13'h200) begin errs++; $display("FAIL prio_first got=%h exp=200", g1); end
    run_frame(12'd1150, g1, g2, first, p);
    vecs++; if (g1 !== 13'h1FC) begin errs++; $display("FAIL prio_hiwins got=%h exp=1fc", g1); end
    thr_upper = 12'd1200;
    thr_lower = 12'd1100;
  endtask

  task automatic test_coarse_clamp();
    logic [12:0] g1, g2;
    logic [11:0] first;
    int p;
    logic [12:0] exp_g [6];
    exp_g = '{13'h480, 13'h4A0, 13'h4C0, 13'h4E0, 13'h500, 13'h500};
    auto_en = 1'b0;
    man_gain = 13'h480;
    tick();
    run_frame(12'd400, g1, g2, first, p);
    vecs++; if (g1 !== 13'h480) begin errs++; $display("FAIL coarse_man got=%h exp=480", g1); end
    vecs++; if (first !== 12'd900) begin errs++; $display("FAIL coarse_data got=%0d exp=900", first); end
    auto_en = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 6; k++) begin
      run_frame(12'd400, g1, g2, first, p);
      vecs++; if (g1 !== exp_g[k]) begin errs++; $display("FAIL coarse_gain[%0d] got=%h exp=%h", k, g1, exp_g[k]); end
      vecs++; if (p !== 1) begin errs++; $display("FAIL coarse_pulse[%0d] got=%0d exp=1", k, p); end
    end
  endtask

  task automatic test_frame_boundary();
    int p, p2;
    fv_in = 1'b1;
    lv_in = 1'b0;
    tick();
    vecs++; if (gain_out !== 13'h500) begin errs++; $display("FAIL fb_start got=%h exp=500", gain_out); end
    lv_in = 1'b1;
    data_in = 12'd400;
    repeat (8) tick();
    auto_en = 1'b0;
    man_gain = 13'h123;
    repeat (8) tick();
    lv_in = 1'b0;
    tick();
    vecs++; if (gain_out !== 13'h500) begin errs++; $display("FAIL fb_midframe got=%h exp=500", gain_out); end
    vblank(p, p2);
    vecs++; if (gain_out !== 13'h500) begin errs++; $display("FAIL fb_vblank got=%h exp=500", gain_out); end
    fv_in = 1'b1;
    tick();
    vecs++; if (gain_out !== 13'h123) begin errs++; $display("FAIL fb_newframe got=%h exp=123", gain_out); end
    vblank(p, p2);
  endtask

  task automatic test_skip();
    logic [12:0] g1, g2;
    logic [11:0] first;
    int p;
    logic [12:0] e1 [5];
    logic [12:0] e2 [5];
    e1 = '{13'h200, 13'h220, 13'h240, 13'h260, 13'h280};
    e2 = '{13'h200, 13'h220, 13'h220, 13'h220, 13'h240};
    auto_en = 1'b1;
    do_reset();
    for (int f = 0; f < 5; f++) begin
      run_frame(12'd400, g1, g2, first, p);
      vecs++; if (g1 !== e1[f]) begin errs++; $display("FAIL skip0_gain[%0d] got=%h exp=%h", f, g1, e1[f]); end
      vecs++; if (g2 !== e2[f]) begin errs++; $display("FAIL skip2_gain[%0d] got=%h exp=%h", f, g2, e2[f]); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [12:0] g1, g2;
    logic [11:0] first;
    int p, p2;
    fv_in = 1'b1;
    lv_in = 1'b0;
    tick();
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 10; x++) begin
        lv_in = (x < 8);
        data_in = (x < 8) ? 12'd4000 : 12'd0;
        tick();
      end
    end
    repeat (4) tick();
    rst = 1'b1;
    tick();
    tick();
    vecs++; if (gain_out2 !== 13'h200) begin errs++; $display("FAIL mrst_gain2 got=%h exp=200", gain_out2); end
    vecs++; if (data_out2 !== 12'd0) begin errs++; $display("FAIL mrst_data2 got=%h exp=0", data_out2); end
    rst = 1'b0;
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 10; x++) begin
        lv_in = (x < 8);
        data_in = (x < 8) ? 12'd400 : 12'd0;
        tick();
      end
    end
    vblank(p, p2);
    vecs++; if (p2 !== 1) begin errs++; $display("FAIL mrst_pulse got=%0d exp=1", p2); end
    run_frame(12'd400, g1, g2, first, p);
    vecs++; if (g2 !== 13'h220) begin errs++; $display("FAIL mrst_gain_next2 got=%h exp=220", g2); end
    vecs++; if (g1 !== 13'h220) begin errs++; $display("FAIL mrst_gain_next got=%h exp=220", g1); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_saturation();
    test_fine_step();
    test_priority();
    test_coarse_clamp();
    test_frame_boundary();
    test_skip();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
